// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared constants, entry layout and immediate helpers for the fetch unit
// Optional feature macro used by the fetch unit: IFU_STATIC_PREDICT_EN
package instruction_fetch_unit_pkg;

    localparam int IFU_IQ_SIZE_LOG = 3;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic ST_SETTLE = 1'b0;
    localparam logic ST_FETCH  = 1'b1;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred_pc;
        logic        compressed;
    } iq_entry_t;

    localparam int IQ_ENTRY_W = $bits(iq_entry_t);

    // Sequential next PC: 16-bit instructions advance by 2, 32-bit ones by 4
    function automatic logic [31:0] fall_through(input logic [31:0] pc, input logic compressed);
        return pc + (compressed ? 32'd2 : 32'd4);
    endfunction

    // Sign-extended J-type immediate
    function automatic logic [31:0] j_imm(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // Sign-extended B-type immediate
    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// instruction_fetch_unit_fetch_queue: circular in-order FIFO with push, deq and flush
module instruction_fetch_unit_fetch_queue #(
    parameter int SIZE_LOG = 3,
    parameter int W        = 97
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         deq,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_data
);

    localparam int DEPTH = 1 << SIZE_LOG;

    logic [W-1:0]      mem [DEPTH];
    logic [SIZE_LOG-1:0] head;
    logic [SIZE_LOG-1:0] tail;
    logic [SIZE_LOG:0]   count;
    logic                do_push;
    logic                do_deq;

    // Full/empty come from the registered count, so a same-cycle deq never frees room for a push
    always_comb begin
        full    = count == (SIZE_LOG + 1)'(DEPTH);
        empty   = count == '0;
        do_push = push && !full;
        do_deq  = deq && !empty;
    end

    assign head_data = mem[head];

    // Pointer and count update; flush empties the queue and overrides push and deq
    always_ff @(posedge clk_in) begin
        if (rst_in || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_deq) head <= head + 1'b1;
            count <= count + (SIZE_LOG + 1)'(do_push) - (SIZE_LOG + 1)'(do_deq);
        end
    end

    // Entry storage; cleared on reset so head outputs read zero after reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (!flush && do_push) begin
            mem[tail] <= push_data;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch PC, settle/fetch FSM and next-PC prediction feeding the instruction queue
// Optional feature macro: IFU_STATIC_PREDICT_EN (backward-taken/forward-not-taken static prediction)
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int          IQ_SIZE_LOG = IFU_IQ_SIZE_LOG,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic [31:0] ic_req_pc,
    input  logic [31:0] ic_inst,
    input  logic        ic_valid,
    input  logic        ic_compressed,
    input  logic        flush_in,
    input  logic [31:0] flush_pc,
    input  logic        iq_deq,
    output logic        iq_out_valid,
    output logic [31:0] iq_out_inst,
    output logic [31:0] iq_out_pc,
    output logic [31:0] iq_out_pred_pc,
    output logic        iq_out_compressed
);

    logic        state;
    logic [31:0] pc;
    logic [31:0] pred_pc;
    logic        iq_full;
    logic        iq_empty;
    logic        push;
    iq_entry_t   push_entry;
    iq_entry_t   head_entry;

`ifdef IFU_STATIC_PREDICT_EN
    // Jumps and backward branches are predicted taken; everything else, JALR included, falls through
    always_comb begin
        pred_pc = fall_through(pc, ic_compressed);
        if (ic_inst[6:0] == OP_JAL) pred_pc = pc + j_imm(ic_inst);
        else if (ic_inst[6:0] == OP_BRANCH && ic_inst[31]) pred_pc = pc + b_imm(ic_inst);
    end
`else
    assign pred_pc = fall_through(pc, ic_compressed);
`endif

    // A response is only taken in FETCH; the SETTLE cycle skips the stale response for the old PC
    always_comb begin
        push       = state == ST_FETCH && ic_valid && !iq_full && !flush_in;
        push_entry = '{inst: ic_inst, pc: pc, pred_pc: pred_pc, compressed: ic_compressed};
    end

    // PC and FSM: reset beats flush, flush beats a push
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc    <= RESET_PC;
            state <= ST_SETTLE;
        end else if (flush_in) begin
            pc    <= {flush_pc[31:1], 1'b0};
            state <= ST_SETTLE;
        end else if (state == ST_SETTLE) begin
            state <= ST_FETCH;
        end else if (push) begin
            pc    <= pred_pc;
            state <= ST_SETTLE;
        end
    end

    instruction_fetch_unit_fetch_queue #(
        .SIZE_LOG(IQ_SIZE_LOG),
        .W       (IQ_ENTRY_W)
    ) u_queue (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .flush    (flush_in),
        .push     (push),
        .push_data(push_entry),
        .deq      (iq_deq && !flush_in),
        .full     (iq_full),
        .empty    (iq_empty),
        .head_data(head_entry)
    );

    assign ic_req_pc         = pc;
    assign iq_out_valid      = !iq_empty;
    assign iq_out_inst       = head_entry.inst;
    assign iq_out_pc         = head_entry.pc;
    assign iq_out_pred_pc    = head_entry.pred_pc;
    assign iq_out_compressed = head_entry.compressed;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] ic_req_pc;
    logic [31:0] ic_inst;
    logic        ic_valid;
    logic        ic_compressed;
    logic        flush_in;
    logic [31:0] flush_pc;
    logic        iq_deq;
    logic        iq_out_valid;
    logic [31:0] iq_out_inst;
    logic [31:0] iq_out_pc;
    logic [31:0] iq_out_pred_pc;
    logic        iq_out_compressed;

    int passed = 0;
    int total  = 0;

    instruction_fetch_unit dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .ic_req_pc        (ic_req_pc),
        .ic_inst          (ic_inst),
        .ic_valid         (ic_valid),
        .ic_compressed    (ic_compressed),
        .flush_in         (flush_in),
        .flush_pc         (flush_pc),
        .iq_deq           (iq_deq),
        .iq_out_valid     (iq_out_valid),
        .iq_out_inst      (iq_out_inst),
        .iq_out_pc        (iq_out_pc),
        .iq_out_pred_pc   (iq_out_pred_pc),
        .iq_out_compressed(iq_out_compressed)
    );

    always #5 clk_in = ~clk_in;

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; flush_in = 1'b1; flush_pc = 32'h500; iq_deq = 1'b1;
        ic_valid = 1'b1; ic_inst = NOP; ic_compressed = 1'b0;
        step(2);
        total++;
        if (ic_req_pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", ic_req_pc, 32'h0);
        else passed++;
        total++;
        if (iq_out_valid !== 1'b0 || iq_out_pc !== 32'h0 || iq_out_inst !== 32'h0 || iq_out_pred_pc !== 32'h0 || iq_out_compressed !== 1'b0)
            $display("FAIL reset_outputs: got valid=%b pc=%h inst=%h pred=%h c=%b want all 0", iq_out_valid, iq_out_pc, iq_out_inst, iq_out_pred_pc, iq_out_compressed);
        else passed++;
        rst_in = 1'b0; flush_in = 1'b0; ic_valid = 1'b0;
        step(3);
        total++;
        if (iq_out_valid !== 1'b0 || ic_req_pc !== 32'h0) $display("FAIL empty_deq: got valid=%b pc=%h want 0 0", iq_out_valid, ic_req_pc);
        else passed++;
        iq_deq = 1'b0;
    endtask

    task automatic test_fill();
        ic_valid = 1'b1;
        step(15);
        total++;
        if (ic_req_pc !== 32'h20) $display("FAIL fill_req_pc: got %h want %h", ic_req_pc, 32'h20);
        else passed++;
        total++;
        if (iq_out_valid !== 1'b1 || iq_out_pc !== 32'h0 || iq_out_pred_pc !== 32'h4 || iq_out_inst !== NOP)
            $display("FAIL fill_head: got valid=%b pc=%h pred=%h inst=%h want 1 0 4 %h", iq_out_valid, iq_out_pc, iq_out_pred_pc, iq_out_inst, NOP);
        else passed++;
        step(4);
        total++;
        if (ic_req_pc !== 32'h20) $display("FAIL no_ninth_push: got %h want %h", ic_req_pc, 32'h20);
        else passed++;
    endtask

    task automatic test_full_deq();
        iq_deq = 1'b1;
        step(1);
        total++;
        if (iq_out_pc !== 32'h4 || ic_req_pc !== 32'h20) $display("FAIL deq_no_push: got head=%h req=%h want 4 20", iq_out_pc, ic_req_pc);
        else passed++;
        iq_deq = 1'b0;
        step(1);
        total++;
        if (ic_req_pc !== 32'h24) $display("FAIL push_after_deq: got %h want %h", ic_req_pc, 32'h24);
        else passed++;
        ic_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (iq_out_valid !== 1'b1 || iq_out_pc !== 32'(4 + 4 * k) || iq_out_pred_pc !== 32'(8 + 4 * k))
                $display("FAIL drain_%0d: got valid=%b pc=%h pred=%h want 1 %h %h", k, iq_out_valid, iq_out_pc, iq_out_pred_pc, 32'(4 + 4 * k), 32'(8 + 4 * k));
            else passed++;
            iq_deq = 1'b1;
            step(1);
        end
        iq_deq = 1'b0;
        total++;
        if (iq_out_valid !== 1'b0) $display("FAIL drained_empty: got %b want 0", iq_out_valid);
        else passed++;
    endtask

    task automatic test_compressed();
        flush_in = 1'b1; flush_pc = 32'h100;
        step(1);
        flush_in = 1'b0; ic_valid = 1'b1; ic_compressed = 1'b1;
        step(2);
        total++;
        if (iq_out_valid !== 1'b1 || iq_out_pc !== 32'h100 || iq_out_pred_pc !== 32'h102 || iq_out_compressed !== 1'b1)
            $display("FAIL compressed_entry: got valid=%b pc=%h pred=%h c=%b want 1 100 102 1", iq_out_valid, iq_out_pc, iq_out_pred_pc, iq_out_compressed);
        else passed++;
        total++;
        if (ic_req_pc !== 32'h102) $display("FAIL compressed_req: got %h want %h", ic_req_pc, 32'h102);
        else passed++;
        ic_compressed = 1'b0;
    endtask

    task automatic test_flush();
        step(1);
        flush_in = 1'b1; flush_pc = 32'h3001; iq_deq = 1'b1;
        step(1);
        flush_in = 1'b0; iq_deq = 1'b0;
        total++;
        if (iq_out_valid !== 1'b0 || ic_req_pc !== 32'h3000) $display("FAIL flush_now: got valid=%b req=%h want 0 3000", iq_out_valid, ic_req_pc);
        else passed++;
        step(1);
        total++;
        if (iq_out_valid !== 1'b0) $display("FAIL flush_settle: got %b want 0", iq_out_valid);
        else passed++;
        step(1);
        total++;
        if (iq_out_valid !== 1'b1 || iq_out_pc !== 32'h3000 || ic_req_pc !== 32'h3004)
            $display("FAIL flush_first_push: got valid=%b pc=%h req=%h want 1 3000 3004", iq_out_valid, iq_out_pc, ic_req_pc);
        else passed++;
    endtask

    task automatic predict_one(input string name, input logic [31:0] inst, input logic [31:0] want);
        flush_in = 1'b1; flush_pc = 32'h40; ic_valid = 1'b1; ic_inst = inst;
        step(1);
        flush_in = 1'b0;
        step(2);
        total++;
        if (iq_out_pc !== 32'h40 || iq_out_pred_pc !== want || ic_req_pc !== want || iq_out_inst !== inst)
            $display("FAIL %s: got pc=%h pred=%h req=%h want 40 %h %h", name, iq_out_pc, iq_out_pred_pc, ic_req_pc, want, want);
        else passed++;
    endtask

    task automatic test_predict();
`ifdef IFU_STATIC_PREDICT_EN
        predict_one("beq_back", 32'hFE00_08E3, 32'h30);
        predict_one("bne_fwd", 32'h0000_1863, 32'h44);
        predict_one("jal", 32'h0010_006F, 32'h840);
`else
        predict_one("beq_back", 32'hFE00_08E3, 32'h44);
        predict_one("bne_fwd", 32'h0000_1863, 32'h44);
        predict_one("jal", 32'h0010_006F, 32'h44);
`endif
        ic_inst = NOP;
    endtask

    task automatic test_stall_reset();
        flush_in = 1'b1; flush_pc = 32'h200; ic_valid = 1'b0;
        step(1);
        flush_in = 1'b0;
        step(1);
        for (int k = 0; k < 5; k++) begin
            step(1);
            total++;
            if (ic_req_pc !== 32'h200 || iq_out_valid !== 1'b0) $display("FAIL stall_%0d: got req=%h valid=%b want 200 0", k, ic_req_pc, iq_out_valid);
            else passed++;
        end
        rst_in = 1'b1;
        step(1);
        rst_in = 1'b0;
        total++;
        if (ic_req_pc !== 32'h0 || iq_out_valid !== 1'b0) $display("FAIL stall_reset: got req=%h valid=%b want 0 0", ic_req_pc, iq_out_valid);
        else passed++;
        ic_valid = 1'b1;
        step(2);
        total++;
        if (iq_out_valid !== 1'b1 || iq_out_pc !== 32'h0 || ic_req_pc !== 32'h4)
            $display("FAIL after_reset_push: got valid=%b pc=%h req=%h want 1 0 4", iq_out_valid, iq_out_pc, ic_req_pc);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_deq();
        test_compressed();
        test_flush();
        test_predict();
        test_stall_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
